pzbcm_lock_arbiter: RTL



---
 rtl/pzbcm_lock_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pzbcm_lock_arbiter.sv
// pzbcm_lock_arbiter
//   N-way arbiter with grant lock, per-requester beat budget and release
//   handling. Round-robin or fixed-priority policy is selected by i_mode.
//   Optional feature macro: PZBCM_LOCK_ARBITER_AGING_EN adds per-requester
//   saturating age counters; saturated requesters win ahead of i_mode.

// Lowest-set-bit picker: one-hot of the lowest set bit plus its binary index.
module pzbcm_lock_arbiter_lsb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o
);
    genvar gi, gb;

    generate
        for (gi = 0; gi < N; gi++) begin : g_oh
            if (gi == 0) begin : g_first
                assign onehot_o[gi] = vec_i[gi];
            end else begin : g_rest
                assign onehot_o[gi] = vec_i[gi] & ~(|vec_i[gi-1:0]);
            end
        end

        // Each index bit is the OR of the one-hot bits whose position has that bit set.
        for (gb = 0; gb < IW; gb++) begin : g_enc
            logic [N-1:0] sel;
            for (gi = 0; gi < N; gi++) begin : g_sel
                if (((gi >> gb) & 1) == 1) begin : g_on
                    assign sel[gi] = onehot_o[gi];
                end else begin : g_off
                    assign sel[gi] = 1'b0;
                end
            end
            assign index_o[gb] = |sel;
        end
    endgenerate
endmodule

module pzbcm_lock_arbiter #(
    parameter int REQUESTS     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int INDEX_WIDTH  = $clog2(REQUESTS),
    parameter int AGE_WIDTH    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_mode,
    input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [REQUESTS-1:0]              i_request,
    input  logic                             i_ack,
    input  logic [REQUESTS-1:0]              i_free,
    output logic [REQUESTS-1:0]              o_grant,
    output logic [INDEX_WIDTH-1:0]           o_grant_index,
    output logic                             o_busy
);
    genvar gi;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Reject configurations the arbitration logic cannot represent.
    generate
        if (REQUESTS < 2 || AGE_WIDTH < 1 || WEIGHT_WIDTH < 1) begin : g_bad_params
            $error("pzbcm_lock_arbiter: REQUESTS>=2, AGE_WIDTH>=1 and WEIGHT_WIDTH>=1 required");
        end
    endgenerate

    state_t                   state_q;
    logic [INDEX_WIDTH-1:0]   ptr_q;
    logic [INDEX_WIDTH-1:0]   ptr_d;
    logic [WEIGHT_WIDTH-1:0]  count_q;
    logic [WEIGHT_WIDTH-1:0]  count_inc;
    logic [WEIGHT_WIDTH-1:0]  weight_q;
    logic [REQUESTS-1:0]      owner_q;
    logic [INDEX_WIDTH-1:0]   owner_idx_q;
    logic                     mode_q;

    logic [WEIGHT_WIDTH-1:0]  weight_arr [REQUESTS];

    logic [REQUESTS-1:0]      ptr_mask;
    logic [REQUESTS-1:0]      rr_hi;
    logic [REQUESTS-1:0]      rr_hi_oh;
    logic [INDEX_WIDTH-1:0]   rr_hi_idx;
    logic [REQUESTS-1:0]      req_oh;
    logic [INDEX_WIDTH-1:0]   req_idx;
    logic [REQUESTS-1:0]      win_oh;
    logic [INDEX_WIDTH-1:0]   win_idx;

    logic                     any_request;
    logic                     owner_free;
    logic                     beat_last;
    logic                     release_now;

    // Split the flat weight bus into one budget per requester.
    generate
        for (gi = 0; gi < REQUESTS; gi++) begin : g_weight
            assign weight_arr[gi] = i_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    // Requesters at or above the round-robin pointer form the first search window.
    generate
        for (gi = 0; gi < REQUESTS; gi++) begin : g_mask
            assign ptr_mask[gi] = (INDEX_WIDTH'(gi) >= ptr_q);
        end
    endgenerate

    assign rr_hi       = i_request & ptr_mask;
    assign any_request = |i_request;

    pzbcm_lock_arbiter_lsb #(
        .N  (REQUESTS),
        .IW (INDEX_WIDTH)
    ) u_lsb_rr_hi (
        .vec_i    (rr_hi),
        .onehot_o (rr_hi_oh),
        .index_o  (rr_hi_idx)
    );

    // Lowest set request serves fixed priority and the round-robin wrap-around.
    pzbcm_lock_arbiter_lsb #(
        .N  (REQUESTS),
        .IW (INDEX_WIDTH)
    ) u_lsb_req (
        .vec_i    (i_request),
        .onehot_o (req_oh),
        .index_o  (req_idx)
    );

`ifdef PZBCM_LOCK_ARBITER_AGING_EN
    logic [AGE_WIDTH-1:0]     age_q [REQUESTS];
    logic [REQUESTS-1:0]      age_sat;
    logic [REQUESTS-1:0]      aged_req;
    logic [REQUESTS-1:0]      aged_oh;
    logic [INDEX_WIDTH-1:0]   aged_idx;

    generate
        for (gi = 0; gi < REQUESTS; gi++) begin : g_age
            assign age_sat[gi] = &age_q[gi];

            // Age a losing requester at each latch; the winner starts over.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    age_q[gi] <= '0;
                end else if (state_q == IDLE && any_request) begin
                    if (win_oh[gi]) begin
                        age_q[gi] <= '0;
                    end else if (i_request[gi] && !age_sat[gi]) begin
                        age_q[gi] <= age_q[gi] + AGE_WIDTH'(1);
                    end
                end
            end
        end
    endgenerate

    assign aged_req = i_request & age_sat;

    pzbcm_lock_arbiter_lsb #(
        .N  (REQUESTS),
        .IW (INDEX_WIDTH)
    ) u_lsb_aged (
        .vec_i    (aged_req),
        .onehot_o (aged_oh),
        .index_o  (aged_idx)
    );

    // Winner: starved requesters first, then the selected policy.
    always_comb begin
        win_oh  = req_oh;
        win_idx = req_idx;
        if (|aged_req) begin
            win_oh  = aged_oh;
            win_idx = aged_idx;
        end else if (!i_mode && |rr_hi) begin
            win_oh  = rr_hi_oh;
            win_idx = rr_hi_idx;
        end
    end
`else
    // Winner: round-robin upper window if it has a request, else lowest index.
    always_comb begin
        win_oh  = req_oh;
        win_idx = req_idx;
        if (!i_mode && |rr_hi) begin
            win_oh  = rr_hi_oh;
            win_idx = rr_hi_idx;
        end
    end
`endif

    assign count_inc   = count_q + WEIGHT_WIDTH'(1);
    assign owner_free  = |(i_free & owner_q);
    assign beat_last   = (weight_q != '0) && i_ack && (count_inc == weight_q);
    assign release_now = (state_q == BUSY) && (owner_free || beat_last);

    // Pointer moves to the requester after the releasing owner, wrapping at REQUESTS.
    always_comb begin
        ptr_d = ptr_q;
        if (release_now && !mode_q) begin
            if (owner_idx_q == INDEX_WIDTH'(REQUESTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = owner_idx_q + INDEX_WIDTH'(1);
            end
        end
    end

    // Lock FSM: latch the winner in IDLE, count beats and release in BUSY.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            weight_q    <= '0;
            owner_q     <= '0;
            owner_idx_q <= '0;
            mode_q      <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                IDLE: begin
                    if (any_request) begin
                        state_q     <= BUSY;
                        owner_q     <= win_oh;
                        owner_idx_q <= win_idx;
                        weight_q    <= weight_arr[win_idx];
                        mode_q      <= i_mode;
                        count_q     <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (i_ack) begin
                        count_q <= count_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant follows the live arbitration in IDLE and the locked owner in BUSY.
    always_comb begin
        o_busy        = (state_q == BUSY);
        o_grant       = win_oh;
        o_grant_index = win_idx;
        if (state_q == BUSY) begin
            o_grant       = owner_q;
            o_grant_index = owner_idx_q;
        end
    end
endmodule
